// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline bus: decoded ID-stage fields going in, latched EX-stage fields coming out.
// The upstream decode/testbench side uses the master modport; the pipeline register uses slave.
interface id_ex_reg_if;
    logic [31:0] ID_Instr_o;
    logic [31:0] ID_PC_o;
    logic [31:0] ID_RD1;
    logic [31:0] ID_RD2;
    logic [31:0] ID_Ext;
    logic [4:0]  ID_RegAddr_i;
    logic [1:0]  ID_Tnew_i;

    logic [31:0] EX_Instr_o;
    logic [31:0] EX_PC_o;
    logic [31:0] EX_PC8_o;
    logic [31:0] EX_RD1_o;
    logic [31:0] EX_RD2_o;
    logic [31:0] EX_Ext_o;
    logic [4:0]  EX_RegAddr_o;
    logic [1:0]  EX_Tnew_o;
    logic [1:0]  EX_Tnew_next_o;
    logic        EX_valid_o;

    modport master (
        output ID_Instr_o, ID_PC_o, ID_RD1, ID_RD2, ID_Ext, ID_RegAddr_i, ID_Tnew_i,
        input  EX_Instr_o, EX_PC_o, EX_PC8_o, EX_RD1_o, EX_RD2_o, EX_Ext_o,
               EX_RegAddr_o, EX_Tnew_o, EX_Tnew_next_o, EX_valid_o
    );

    modport slave (
        input  ID_Instr_o, ID_PC_o, ID_RD1, ID_RD2, ID_Ext, ID_RegAddr_i, ID_Tnew_i,
        output EX_Instr_o, EX_PC_o, EX_PC8_o, EX_RD1_o, EX_RD2_o, EX_Ext_o,
               EX_RegAddr_o, EX_Tnew_o, EX_Tnew_next_o, EX_valid_o
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register of the 5-stage MIPS core.
// Loads decoded operands into EX, inserts an all-zero nop bubble on stall/flush,
// and keeps saturating counters of stall bubbles and issued instructions.
module id_ex_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    id_ex_reg_if.slave       bus,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      instr_q,    instr_d;
    logic [31:0]      pc_q,       pc_d;
    logic [31:0]      rd1_q,      rd1_d;
    logic [31:0]      rd2_q,      rd2_d;
    logic [31:0]      ext_q,      ext_d;
    logic [4:0]       regAddr_q,  regAddr_d;
    logic [1:0]       tnew_q,     tnew_d;
    logic             valid_q,    valid_d;
    logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
    logic [CNT_W-1:0] issueCnt_q,  issueCnt_d;

    logic             insertBubble;
    logic [1:0]       tnewLoad;

    assign insertBubble = stall | flush;

    // Writes to $0 never create a hazard, and the illegal Tnew of 3 is clamped to 2.
    always_comb begin
        tnewLoad = bus.ID_Tnew_i;
        if (bus.ID_RegAddr_i == 5'd0) begin
            tnewLoad = 2'd0;
        end else if (bus.ID_Tnew_i == 2'd3) begin
            tnewLoad = 2'd2;
        end
    end

    // Next-state: a bubble zeroes every field (sll $0 nop); otherwise capture ID.
    always_comb begin
        instr_d     = bus.ID_Instr_o;
        pc_d        = bus.ID_PC_o;
        rd1_d       = bus.ID_RD1;
        rd2_d       = bus.ID_RD2;
        ext_d       = bus.ID_Ext;
        regAddr_d   = bus.ID_RegAddr_i;
        tnew_d      = tnewLoad;
        valid_d     = 1'b1;
        bubbleCnt_d = bubbleCnt_q;
        issueCnt_d  = issueCnt_q;
        if (insertBubble) begin
            instr_d   = 32'd0;
            pc_d      = 32'd0;
            rd1_d     = 32'd0;
            rd2_d     = 32'd0;
            ext_d     = 32'd0;
            regAddr_d = 5'd0;
            tnew_d    = 2'd0;
            valid_d   = 1'b0;
            if (stall && (bubbleCnt_q != CNT_MAX)) begin
                bubbleCnt_d = bubbleCnt_q + 1'b1;
            end
        end else if (issueCnt_q != CNT_MAX) begin
            issueCnt_d = issueCnt_q + 1'b1;
        end
    end

    // State update; synchronous active-low reset overrides everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_q     <= 32'd0;
            pc_q        <= 32'd0;
            rd1_q       <= 32'd0;
            rd2_q       <= 32'd0;
            ext_q       <= 32'd0;
            regAddr_q   <= 5'd0;
            tnew_q      <= 2'd0;
            valid_q     <= 1'b0;
            bubbleCnt_q <= '0;
            issueCnt_q  <= '0;
        end else begin
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            ext_q       <= ext_d;
            regAddr_q   <= regAddr_d;
            tnew_q      <= tnew_d;
            valid_q     <= valid_d;
            bubbleCnt_q <= bubbleCnt_d;
            issueCnt_q  <= issueCnt_d;
        end
    end

    assign bus.EX_Instr_o     = instr_q;
    assign bus.EX_PC_o        = pc_q;
    assign bus.EX_PC8_o       = pc_q + 32'd8;
    assign bus.EX_RD1_o       = rd1_q;
    assign bus.EX_RD2_o       = rd2_q;
    assign bus.EX_Ext_o       = ext_q;
    assign bus.EX_RegAddr_o   = regAddr_q;
    assign bus.EX_Tnew_o      = tnew_q;
    assign bus.EX_Tnew_next_o = (tnew_q == 2'd0) ? 2'd0 : tnew_q - 2'd1;
    assign bus.EX_valid_o     = valid_q;
    assign bubble_cnt         = bubbleCnt_q;
    assign issue_cnt          = issueCnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: each driven cycle pushes the model's expected EX state
// into a scoreboard queue, which is popped and compared just after the clock edge.
module tb_id_ex_reg;

    localparam int TB_CNT_W = 2;
    localparam logic [TB_CNT_W-1:0] TB_CNT_MAX = {TB_CNT_W{1'b1}};

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [4:0]  regAddr;
        logic [1:0]  tnew;
        logic [1:0]  tnewNext;
        logic        valid;
        logic [TB_CNT_W-1:0] bubbleCnt;
        logic [TB_CNT_W-1:0] issueCnt;
    } expState_t;

    logic clk;
    logic reset;
    logic stall;
    logic flush;
    logic [TB_CNT_W-1:0] bubble_cnt;
    logic [TB_CNT_W-1:0] issue_cnt;

    id_ex_reg_if busIf ();

    id_ex_reg #(.CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .bus        (busIf.slave),
        .bubble_cnt (bubble_cnt),
        .issue_cnt  (issue_cnt)
    );

    expState_t scoreQ[$];
    expState_t modelState;
    int checkCount = 0;
    int failCount  = 0;
    int stepNum    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model of one clock edge, independent of the RTL structure.
    task automatic modelEdge(input logic rst, input logic stl, input logic fls,
                             input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [31:0] ext, input logic [4:0] ra,
                             input logic [1:0] tn);
        if (!rst) begin
            modelState = '0;
        end else if (stl || fls) begin
            modelState.instr   = 0;
            modelState.pc      = 0;
            modelState.rd1     = 0;
            modelState.rd2     = 0;
            modelState.ext     = 0;
            modelState.regAddr = 0;
            modelState.tnew    = 0;
            modelState.valid   = 0;
            if (stl && modelState.bubbleCnt < TB_CNT_MAX) modelState.bubbleCnt++;
        end else begin
            modelState.instr   = instr;
            modelState.pc      = pc;
            modelState.rd1     = rd1;
            modelState.rd2     = rd2;
            modelState.ext     = ext;
            modelState.regAddr = ra;
            if (ra == 0)       modelState.tnew = 0;
            else if (tn == 3)  modelState.tnew = 2;
            else               modelState.tnew = tn;
            modelState.valid   = 1;
            if (modelState.issueCnt < TB_CNT_MAX) modelState.issueCnt++;
        end
        modelState.pc8      = modelState.pc + 32'd8;
        modelState.tnewNext = (modelState.tnew > 0) ? modelState.tnew - 2'd1 : 2'd0;
    endtask

    task automatic compareAll();
        expState_t e;
        string t;
        if (scoreQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = scoreQ.pop_front();
        t = $sformatf("s%0d", stepNum);
        checkOutput({t, "_instr"},     busIf.EX_Instr_o,             e.instr);
        checkOutput({t, "_pc"},        busIf.EX_PC_o,                e.pc);
        checkOutput({t, "_pc8"},       busIf.EX_PC8_o,               e.pc8);
        checkOutput({t, "_rd1"},       busIf.EX_RD1_o,               e.rd1);
        checkOutput({t, "_rd2"},       busIf.EX_RD2_o,               e.rd2);
        checkOutput({t, "_ext"},       busIf.EX_Ext_o,               e.ext);
        checkOutput({t, "_regaddr"},   {27'd0, busIf.EX_RegAddr_o},  {27'd0, e.regAddr});
        checkOutput({t, "_tnew"},      {30'd0, busIf.EX_Tnew_o},     {30'd0, e.tnew});
        checkOutput({t, "_tnew_next"}, {30'd0, busIf.EX_Tnew_next_o},{30'd0, e.tnewNext});
        checkOutput({t, "_valid"},     {31'd0, busIf.EX_valid_o},    {31'd0, e.valid});
        checkOutput({t, "_bubble_cnt"},{30'd0, bubble_cnt},          {30'd0, e.bubbleCnt});
        checkOutput({t, "_issue_cnt"}, {30'd0, issue_cnt},           {30'd0, e.issueCnt});
    endtask

    // Drive one cycle of stimulus away from the edge, record expectation, compare after edge.
    task automatic applyStimulus(input logic rst, input logic stl, input logic fls,
                                 input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic [31:0] ext, input logic [4:0] ra,
                                 input logic [1:0] tn);
        @(negedge clk);
        reset                 = rst;
        stall                 = stl;
        flush                 = fls;
        busIf.ID_Instr_o      = instr;
        busIf.ID_PC_o         = pc;
        busIf.ID_RD1          = rd1;
        busIf.ID_RD2          = rd2;
        busIf.ID_Ext          = ext;
        busIf.ID_RegAddr_i    = ra;
        busIf.ID_Tnew_i       = tn;
        modelEdge(rst, stl, fls, instr, pc, rd1, rd2, ext, ra, tn);
        scoreQ.push_back(modelState);
        @(posedge clk);
        #1;
        stepNum++;
        compareAll();
    endtask

    localparam logic [31:0] ADDU3 = 32'h0022_1821;
    localparam logic [31:0] LW4   = 32'h8C24_0010;
    localparam logic [31:0] BEQ   = 32'h1084_0003;

    initial begin
        modelState = '0;
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        busIf.ID_Instr_o = 0; busIf.ID_PC_o = 0; busIf.ID_RD1 = 0; busIf.ID_RD2 = 0;
        busIf.ID_Ext = 0; busIf.ID_RegAddr_i = 0; busIf.ID_Tnew_i = 0;

        // Reset held two cycles with live data on the inputs
        applyStimulus(0, 0, 0, ADDU3, 32'h1234, 32'hDEADBEEF, 32'h55, 32'h66, 5'd7, 2'd1);
        applyStimulus(0, 0, 0, ADDU3, 32'h1234, 32'hDEADBEEF, 32'h55, 32'h66, 5'd7, 2'd1);

        // addu $3 load
        applyStimulus(1, 0, 0, ADDU3, 32'h3000, 32'd5, 32'd7, 32'h0, 5'd3, 2'd1);
        // lw $4 then beq stalled two cycles, loading on the third edge
        applyStimulus(1, 0, 0, LW4,   32'h3004, 32'd9, 32'd1, 32'h10, 5'd4, 2'd2);
        applyStimulus(1, 1, 0, BEQ,   32'h3008, 32'hA, 32'hB, 32'h3, 5'd0, 2'd0);
        applyStimulus(1, 1, 0, BEQ,   32'h3008, 32'hA, 32'hB, 32'h3, 5'd0, 2'd0);
        applyStimulus(1, 0, 0, BEQ,   32'h3008, 32'hA, 32'hB, 32'h3, 5'd0, 2'd0);
        // $0 destination with nonzero Tnew
        applyStimulus(1, 0, 0, ADDU3, 32'h300C, 32'h1, 32'h2, 32'h4, 5'd0, 2'd2);
        // flush+stall together, then flush alone
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 2'd0);
        applyStimulus(1, 0, 0, ADDU3, 32'h4000, 32'h11, 32'h22, 32'h33, 5'd5, 2'd1);
        applyStimulus(1, 1, 1, ADDU3, 32'h4004, 32'h44, 32'h55, 32'h66, 5'd6, 2'd2);
        applyStimulus(1, 0, 1, ADDU3, 32'h4008, 32'h77, 32'h88, 32'h99, 5'd7, 2'd1);

        // Saturation of bubble_cnt after five stalls
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, ADDU3, 32'h5000, 32'h1, 32'h2, 32'h3, 5'd9, 2'd1);
        end
        // PC wrap, Tnew clamp, issue_cnt saturation
        applyStimulus(1, 0, 0, ADDU3, 32'hFFFF_FFFC, 32'h1, 32'h2, 32'h3, 5'd9, 2'd1);
        applyStimulus(1, 0, 0, LW4,   32'h0000_0000, 32'h4, 32'h5, 32'h6, 5'd10, 2'd3);
        applyStimulus(1, 0, 0, LW4,   32'h0000_0004, 32'h7, 32'h8, 32'h9, 5'd11, 2'd2);
        applyStimulus(1, 0, 0, LW4,   32'h0000_0008, 32'hA, 32'hB, 32'hC, 5'd12, 2'd1);

        // Reset asserted mid-stall, then a stall right after release
        applyStimulus(1, 1, 0, BEQ, 32'h6000, 32'h1, 32'h1, 32'h1, 5'd1, 2'd1);
        applyStimulus(0, 1, 0, BEQ, 32'h6000, 32'h1, 32'h1, 32'h1, 5'd1, 2'd1);
        applyStimulus(1, 1, 0, BEQ, 32'h6000, 32'h1, 32'h1, 32'h1, 5'd1, 2'd1);
        applyStimulus(1, 0, 0, BEQ, 32'h6000, 32'h1, 32'h1, 32'h1, 5'd1, 2'd1);

        // Mixed random traffic
        for (int i = 0; i < 24; i++) begin
            applyStimulus(($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 5) == 0),
                          $urandom, $urandom, $urandom, $urandom, $urandom,
                          5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Consumes the hazard unit's stall decision and inserts a bubble into EX when ID must hold.
- Latches decoded operands, destination register and Tnew for the EX stage.
- Feeds EX_RegAddr_o/EX_Tnew_o back to the hazard unit, and provides a pre-decremented Tnew and performance counters for EX/MEM.

Parameters:
- CNT_W, 16, width of the saturating stall-bubble and issued-instruction counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset
- stall  input  1  hazard stall from the hazard unit (equals !en_IDtoEX); 1 = insert bubble
- flush  input  1  squash the ID instruction (bubble), from control
- ID_Instr_o  input  32  instruction in ID
- ID_PC_o  input  32  PC of instruction in ID
- ID_RD1  input  32  forwarded rs value
- ID_RD2  input  32  forwarded rt value
- ID_Ext  input  32  extended immediate
- ID_RegAddr_i  input  5  destination GPR (0 = none)
- ID_Tnew_i  input  2  EX-relative Tnew from the hazard unit decode
- EX_Instr_o  output  32  latched instruction
- EX_PC_o  output  32  latched PC
- EX_PC8_o  output  32  EX_PC_o + 8 (jal link value)
- EX_RD1_o  output  32  latched rs value
- EX_RD2_o  output  32  latched rt value
- EX_Ext_o  output  32  latched immediate
- EX_RegAddr_o  output  5  destination GPR in EX
- EX_Tnew_o  output  2  Tnew of EX instruction
- EX_Tnew_next_o  output  2  saturating EX_Tnew_o-1, for EX/MEM
- EX_valid_o  output  1  1 = real instruction, 0 = bubble
- bubble_cnt  output  CNT_W  saturating count of stall-inserted bubbles
- issue_cnt  output  CNT_W  saturating count of valid instructions entering EX

Behaviour:
- All state updates only on posedge clk.
- Reset (reset==0 at the edge) has top priority. It clears:
  - every data output to 0 (EX_PC8_o then reads 8, being combinational)
  - EX_RegAddr_o=0, EX_Tnew_o=0, EX_valid_o=0
  - both counters to 0
- Priority per edge: reset > (flush or stall) > load.
- Bubble (flush==1 or stall==1): Instr, PC, RD1, RD2, Ext, RegAddr, Tnew and valid all load 0.
  - Result is an architectural sll $0 nop.
  - No input value leaks into EX.
- Load (both 0): every field captures its ID input, EX_valid_o=1, with two exceptions:
  - ID_RegAddr_i==0 loads EX_Tnew_o=0 regardless of ID_Tnew_i. Writes to $0 never create a hazard.
  - ID_Tnew_i==3 is illegal; it is stored as 2.
- Latency: exactly 1 cycle from ID inputs to EX outputs; no combinational input-to-output path except EX_PC8_o and EX_Tnew_next_o, which derive from registers only.
- EX_Tnew_next_o = (EX_Tnew_o==0) ? 0 : EX_Tnew_o-1.
- EX_PC8_o = EX_PC_o + 8, modulo 2^32 (wraps: 0xFFFFFFFC -> 0x00000004).
- bubble_cnt:
  - +1 on each non-reset edge with stall==1 (also when flush is high in the same cycle).
  - A flush-only edge does not count.
  - Saturates at 2^CNT_W-1.
- issue_cnt: +1 on each load edge; saturates at 2^CNT_W-1.
- Consecutive stall cycles: a bubble every cycle; the ID inputs are held upstream and load on the first cycle stall drops.
- Reset asserted mid-stall: reset wins and counters clear. The first edge after release follows stall/flush normally.
- The register never stalls itself: it always advances (bubble or load).

Test Plan:
- Reset: hold reset=0 two cycles with ID_RD1=0xDEADBEEF, stall=0 -> all outputs 0, EX_PC8_o=8, counters 0.
- Load: addu $3 (ID_RegAddr_i=3, ID_Tnew_i=1, PC=0x3000, RD1=5, RD2=7), stall=flush=0 -> after one edge:
  - EX_RegAddr_o=3, EX_Tnew_o=1, EX_Tnew_next_o=0
  - EX_PC8_o=0x3008, EX_valid_o=1, issue_cnt=1
- Stall bubble: lw $4 in EX, beq in ID, stall=1 for 2 cycles -> each edge EX_Instr_o=0, EX_RegAddr_o=0, EX_valid_o=0; bubble_cnt=2; beq loads on the third edge once stall=0.
- $0 destination: ID_RegAddr_i=0, ID_Tnew_i=2 -> EX_Tnew_o=0, EX_valid_o=1.
- Flush+stall together for one edge -> bubble, bubble_cnt+1, issue_cnt unchanged. Flush alone -> bubble, both counters unchanged.
- Saturation/wrap with CNT_W=2:
  - 5 stall edges -> bubble_cnt=3.
  - Load PC=0xFFFFFFFC -> EX_PC8_o=0x00000004.
  - ID_Tnew_i=3 -> EX_Tnew_o=2.
